// File: rtl/banked_ram_dp_clr_pkg.sv
// Shared types and constants for the banked dual-port RAM with clear engine.
package ram_pkg;

   typedef enum logic {CLEAR, READY} clr_state_t;

   // Same-address dual-write winner select
   localparam int unsigned COLLIDE_A = 0;
   localparam int unsigned COLLIDE_B = 1;

   // Supported read latency range, in cycles
   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 3;

   function automatic bit rd_latency_ok(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/banked_ram_dp_clr_if.sv
// Bundled user-side ports of the banked RAM: clear request, ready, and per-bank A/B ports.
interface banked_ram_dp_clr_if #(
   parameter int unsigned BANKS   = 32,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ADDRESS = 10
);
   logic                              clr_req;
   logic                              ready;
   logic [BANKS-1:0]                  ena;
   logic [BANKS-1:0]                  enb;
   logic [BANKS-1:0]                  wea;
   logic [BANKS-1:0]                  web;
   logic [BANKS-1:0][ADDRESS-1:0]     addra;
   logic [BANKS-1:0][ADDRESS-1:0]     addrb;
   logic [BANKS-1:0][WIDTH-1:0]       dina;
   logic [BANKS-1:0][WIDTH-1:0]       dinb;
   logic [BANKS-1:0][WIDTH-1:0]       douta;
   logic [BANKS-1:0][WIDTH-1:0]       doutb;
   logic [BANKS-1:0]                  valida;
   logic [BANKS-1:0]                  validb;
   logic [BANKS-1:0]                  collide;

   modport master (
      output clr_req, ena, enb, wea, web, addra, addrb, dina, dinb,
      input  ready, douta, doutb, valida, validb, collide
   );

   modport slave (
      input  clr_req, ena, enb, wea, web, addra, addrb, dina, dinb,
      output ready, douta, doutb, valida, validb, collide
   );
endinterface

// File: rtl/banked_ram_dp_clr_bank.sv
// One dual-port read-first RAM bank with collision resolution and a read-latency pipeline.
module ram_bank_dp
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned ADDRESS      = 10,
   parameter int unsigned RD_LATENCY   = 1,
   parameter int unsigned COLLIDE_MODE = COLLIDE_A
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_a,
   input  logic               we_a,
   input  logic               vreq_a,
   input  logic [ADDRESS-1:0] addr_a,
   input  logic [WIDTH-1:0]   din_a,
   output logic [WIDTH-1:0]   dout_a,
   output logic               valid_a,
   input  logic               en_b,
   input  logic               we_b,
   input  logic               vreq_b,
   input  logic [ADDRESS-1:0] addr_b,
   input  logic [WIDTH-1:0]   din_b,
   output logic [WIDTH-1:0]   dout_b,
   output logic               valid_b,
   output logic               collide
);
   localparam int unsigned DEPTH = 2**ADDRESS;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic                  wr_a, wr_b, both, keep_a, keep_b;
   logic [1:0]            vreq;
   logic [ADDRESS-1:0]    raddr [2];
   logic [WIDTH-1:0]      pipe  [2][RD_LATENCY];
   logic [RD_LATENCY-1:0] vld   [2];

   assign wr_a   = en_a & we_a;
   assign wr_b   = en_b & we_b;
   assign both   = wr_a & wr_b & (addr_a == addr_b);
   // The losing port of a same-address dual write is simply suppressed
   assign keep_a = wr_a & ~(both & (COLLIDE_MODE == COLLIDE_B));
   assign keep_b = wr_b & ~(both & (COLLIDE_MODE == COLLIDE_A));

   assign vreq     = {vreq_b, vreq_a};
   assign raddr[0] = addr_a;
   assign raddr[1] = addr_b;

   // Memory array write; no reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (keep_a) mem[addr_a] <= din_a;
      if (keep_b) mem[addr_b] <= din_b;
   end

   // Read-first capture and latency pipeline; each stage only advances on valid so dout holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned p = 0; p < 2; p++) begin
            vld[p] <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) pipe[p][i] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < 2; p++) begin
            vld[p][0] <= vreq[p];
            if (vreq[p]) pipe[p][0] <= mem[raddr[p]];
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
               vld[p][i] <= vld[p][i-1];
               if (vld[p][i-1]) pipe[p][i] <= pipe[p][i-1];
            end
         end
      end
   end

   // Collision flag, one cycle after the colliding writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) collide <= 1'b0;
      else        collide <= both;
   end

   assign dout_a  = pipe[0][RD_LATENCY-1];
   assign valid_a = vld[0][RD_LATENCY-1];
   assign dout_b  = pipe[1][RD_LATENCY-1];
   assign valid_b = vld[1][RD_LATENCY-1];

endmodule

// File: rtl/banked_ram_dp_clr.sv
// Banked true-dual-port RAM with clear engine: holds the clear FSM and per-bank port muxing.
module banked_ram_dp_clr
   import ram_pkg::*;
#(
   parameter int unsigned BANKS        = 32,
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned ADDRESS      = 10,
   parameter int unsigned RD_LATENCY   = 1,
   parameter int unsigned COLLIDE_MODE = COLLIDE_A
) (
   input logic                clk,
   input logic                rst_n,
   banked_ram_dp_clr_if.slave bus
);
   if (!rd_latency_ok(RD_LATENCY)) begin : g_lat_err
      $error("banked_ram_dp_clr: RD_LATENCY must be 1..3");
   end

   clr_state_t         state;
   logic [ADDRESS-1:0] cnt;
   logic               ready_q;
   logic               clearing;

   // Clear FSM: sweep cnt over every address, then accept user traffic until a clear request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR;
         cnt     <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (bus.clr_req) begin
                  cnt <= '0;
               end else if (cnt == '1) begin
                  state   <= READY;
                  ready_q <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READY: begin
               if (bus.clr_req) begin
                  state   <= CLEAR;
                  ready_q <= 1'b0;
                  cnt     <= '0;
               end
            end
            default: begin
               state   <= CLEAR;
               ready_q <= 1'b0;
               cnt     <= '0;
            end
         endcase
      end
   end

   assign clearing  = (state == CLEAR);
   assign bus.ready = ready_q;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic               a_en, a_we, a_vreq, b_en, b_we;
      logic [ADDRESS-1:0] a_addr;
      logic [WIDTH-1:0]   a_din;

      // While clearing, port A is owned by the clear engine and never flags valid
      assign a_en   = clearing | bus.ena[b];
      assign a_we   = clearing | bus.wea[b];
      assign a_vreq = ~clearing & bus.ena[b];
      assign a_addr = clearing ? cnt : bus.addra[b];
      assign a_din  = clearing ? '0  : bus.dina[b];
      assign b_en   = ~clearing & bus.enb[b];
      assign b_we   = bus.web[b];

      ram_bank_dp #(
         .WIDTH       (WIDTH),
         .ADDRESS     (ADDRESS),
         .RD_LATENCY  (RD_LATENCY),
         .COLLIDE_MODE(COLLIDE_MODE)
      ) u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_a   (a_en),
         .we_a   (a_we),
         .vreq_a (a_vreq),
         .addr_a (a_addr),
         .din_a  (a_din),
         .dout_a (bus.douta[b]),
         .valid_a(bus.valida[b]),
         .en_b   (b_en),
         .we_b   (b_we),
         .vreq_b (b_en),
         .addr_b (bus.addrb[b]),
         .din_b  (bus.dinb[b]),
         .dout_b (bus.doutb[b]),
         .valid_b(bus.validb[b]),
         .collide(bus.collide[b])
      );
   end

endmodule
